// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and busy-register scoreboard for the single-write-port register file.
// ALU and load results share the port round-robin; decode reads hazard1/hazard2 to stall on RAW.
module regfile_wb_arbiter #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  localparam int RW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [RW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [RW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rd,
  input  logic [RW-1:0]   rs1,
  input  logic [RW-1:0]   rs2,
  output logic            hazard1,
  output logic            hazard2,
  output logic            wer,
  output logic [RW-1:0]   rd,
  output logic [XLEN-1:0] regdata,
  output logic [5:0]      pending_cnt,
  output logic            orphan_err
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } src_e;

  src_e            last_grant;
  src_e            last_grant_next;
  logic            accept;
  logic [RW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic            orphan_hit;

  function automatic logic [5:0] popcount(input logic [NREG-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) cnt = cnt + 6'(v[i]);
    return cnt;
  endfunction

  // Readies depend only on valids and last_grant, never on each other.
  always_comb begin
    alu_ready       = alu_valid && (!ld_valid || last_grant == SRC_LD);
    ld_ready        = ld_valid && (!alu_valid || last_grant == SRC_ALU);
    accept          = alu_ready || ld_ready;
    sel_rd          = alu_ready ? alu_rd : ld_rd;
    sel_data        = alu_ready ? alu_data : ld_data;
    last_grant_next = last_grant;
    if (alu_ready)     last_grant_next = SRC_ALU;
    else if (ld_ready) last_grant_next = SRC_LD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant <= SRC_LD;
    else     last_grant <= last_grant_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wer     <= 1'b0;
      rd      <= '0;
      regdata <= '0;
    end else if (accept) begin
      wer     <= (sel_rd != '0);
      rd      <= sel_rd;
      regdata <= sel_data;
    end else begin
      wer     <= 1'b0;
    end
  end

  // A same-edge issue of the committing register re-arms it, so set beats clear.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_rd != '0) set_vec[issue_rd] = 1'b1;
    if (wer) clr_vec[rd] = 1'b1;
    busy_next    = (busy & ~clr_vec) | set_vec;
    busy_next[0] = 1'b0;
    orphan_hit   = wer && !busy[rd] && !set_vec[rd];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= '0;
      pending_cnt <= '0;
      orphan_err  <= 1'b0;
    end else begin
      busy        <= busy_next;
      pending_cnt <= popcount(busy_next);
      if (orphan_hit) orphan_err <= 1'b1;
    end
  end

  assign hazard1 = busy[rs1];
  assign hazard2 = busy[rs2];

endmodule
